// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/handshake and control bundle between the main FSM and the datapath
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  // Controller side: consumes opcode and memory handshake, drives every control
  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           illegal_op, mem_timeout, state
  );

  // Datapath side
  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM; MCTRL_ADDI_EN adds the addi path
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);
  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`ifdef MCTRL_ADDI_EN
    ,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       wait_state;
  logic       mem_stall;
  logic       timeout_hit;

  // State, wait counter and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, wait-counter and Moore control decode
  always_comb begin
    state_d         = state_q;
    illegal_d       = 1'b0;
    timeout_d       = 1'b0;
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.aluop       = 2'b00;
    bus.pcsource    = 2'b00;

    // Only the three memory-access states can stall; the counter restarts
    // whenever the state is left (including a timeout re-entry of FETCH).
    wait_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    mem_stall   = wait_state && !bus.mem_ready;
    timeout_hit = mem_stall && (wait_q == WAIT_MAX);
    wait_d      = (mem_stall && !timeout_hit) ? wait_q + 8'd1 : 8'd0;

    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MCTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.aluop       = 2'b01;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b01;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = 2'b10;
        state_d      = S_FETCH;
      end
`ifdef MCTRL_ADDI_EN
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // A ready memory on the last allowed cycle still completes normally;
    // only a stall at the limit abandons the access.
    if (timeout_hit) begin
      state_d   = S_FETCH;
      timeout_d = 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with randomized instruction stream
module tb_multicycle_control;
  localparam int MAXW = 15;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [21:0] word;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  bit   pend_ill = 1'b0;
  bit   pend_to  = 1'b0;

  // Control word per state as listed in the state output table
  function automatic logic [21:0] exp_word(int st, bit mr, bit ill, bit to);
    bit pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
    bit [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; pw = mr; irw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
      9:  begin pw = 1; psrc = 2'd2; end
      10: begin asa = 1; asb = 2'd2; end
      11: rw = 1;
      default: ;
    endcase
    return {4'(st), pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, to};
  endfunction

  // Instruction class: 0 illegal, 1 R, 2 lw, 3 sw, 4 beq, 5 j, 6 addi
  function automatic int op_kind(logic [5:0] o);
    case (o)
      6'b000000: return 1;
      6'b100011: return 2;
      6'b101011: return 3;
      6'b000100: return 4;
      6'b000010: return 5;
`ifdef MCTRL_ADDI_EN
      6'b001000: return 6;
`endif
      default:   return 0;
    endcase
  endfunction

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 9));
    if (r <= 5) return 0;
    if (r == 6) return int'($urandom_range(1, 3));
    if (r == 7) return MAXW;
    if (r == 8) return MAXW + 1;
    return int'($urandom_range(0, MAXW));
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs for this cycle
  task automatic cyc(int st, bit mr, bit rst, bit chk);
    exp_t e;
    e.chk  = chk;
    e.word = exp_word(st, mr, pend_ill, pend_to);
    e.cyc  = cyc_no;
    pend_ill = 1'b0;
    pend_to  = 1'b0;
    bus.mem_ready = mr;
    reset = rst;
    sbq.push_back(e);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  // A stalling memory state: 'zeros' not-ready cycles; more than MAXW times out
  task automatic wait_state(int st, int zeros, output bit timed_out);
    int n = (zeros > MAXW) ? MAXW + 1 : zeros;
    timed_out = 1'b0;
    for (int i = 0; i < n; i++) cyc(st, 1'b0, 1'b0, 1'b1);
    if (zeros > MAXW) begin
      timed_out = 1'b1;
      pend_to   = 1'b1;
    end else begin
      cyc(st, 1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic run_instr(logic [5:0] o, int fetch_w, int mem_w);
    bit to;
    int w = fetch_w;
    bus.op = o;
    do begin
      wait_state(0, w, to);
      w = pick_wait();
    end while (to);
    cyc(1, 1'($urandom), 1'b0, 1'b1);
    case (op_kind(o))
      1: begin cyc(6, 1'($urandom), 1'b0, 1'b1); cyc(7, 1'($urandom), 1'b0, 1'b1); end
      2: begin
        cyc(2, 1'($urandom), 1'b0, 1'b1);
        wait_state(3, mem_w, to);
        if (!to) cyc(4, 1'($urandom), 1'b0, 1'b1);
      end
      3: begin
        cyc(2, 1'($urandom), 1'b0, 1'b1);
        wait_state(5, mem_w, to);
      end
      4: cyc(8, 1'($urandom), 1'b0, 1'b1);
      5: cyc(9, 1'($urandom), 1'b0, 1'b1);
      6: begin cyc(10, 1'($urandom), 1'b0, 1'b1); cyc(11, 1'($urandom), 1'b0, 1'b1); end
      default: pend_ill = 1'b1;
    endcase
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare it
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [21:0] act;
      e = sbq.pop_front();
      act = {bus.state, bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
             bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
             bus.aluop, bus.pcsource, bus.illegal_op, bus.mem_timeout};
      if (e.chk) begin
        checks++;
        if (act !== e.word) begin
          errors++;
          $display("FAIL ctrl_word cycle %0d: got state=%0d word=%h, required state=%0d word=%h",
                   e.cyc, act[21:18], act, e.word[21:18], e.word);
        end
      end
    end
  end

  initial begin
    logic [5:0] o;
    int k;
    reset = 1'b1;
    bus.op = 6'd0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset held two cycles with memory ready
    cyc(0, 1'b1, 1'b1, 1'b1);
    cyc(0, 1'b1, 1'b1, 1'b1);
    // Directed: R, lw with three stalls in MEMRD, sw, beq, j, illegal, addi
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 0, 0);
    // Fetch stalls: timeout, then exactly-at-limit completion
    run_instr(6'b000000, MAXW + 1, 0);
    run_instr(6'b000000, MAXW, 0);
    // MEMRD timeout skips MEMWB; MEMWR limit boundary
    run_instr(6'b100011, 0, MAXW + 1);
    run_instr(6'b101011, 0, MAXW);
    // Reset while waiting in MEMWR abandons the store
    bus.op = 6'b101011;
    cyc(0, 1'b1, 1'b0, 1'b1);
    cyc(1, 1'b1, 1'b0, 1'b1);
    cyc(2, 1'b1, 1'b0, 1'b1);
    cyc(5, 1'b0, 1'b0, 1'b1);
    cyc(5, 1'b0, 1'b1, 1'b1);
    run_instr(6'b000000, 0, 0);
    // Randomized instruction stream
    for (int i = 0; i < 250; i++) begin
      k = int'($urandom_range(0, 7));
      case (k)
        0, 7: o = 6'b000000;
        1: o = 6'b100011;
        2: o = 6'b101011;
        3: o = 6'b000100;
        4: o = 6'b000010;
        5: o = 6'b001000;
        default: o = 6'($urandom);
      endcase
      run_instr(o, pick_wait(), pick_wait());
    end
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
